game_state_ctrl: RTL
====================

# game_state_ctrl

Top-level game sequencer: owns the 2-bit game state and walks MENU → READY → GAME → SCORE → MENU. Drives the game timer's `state_in` and `time_in`, consumes its `end_of_time` pulse, and times the READY countdown and SCORE hold itself from an internal one-second tick. Sits between the debounced player buttons and the game timer and render modules.

## Interface
- `CLK_HZ`, 100_000_000: clock frequency; the one-second tick period in cycles.
- `READY_S`, 3: READY countdown length in seconds, 1..15.
- `SCORE_S`, 10: SCORE hold length in seconds, 1..255.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `start_btn`  in  1  debounced start button, level.
- `time_sel`  in  2  round length select: 0=30 s, 1=60 s, 2=90 s, 3=120 s.
- `end_of_time`  in  1  one-cycle pulse from the game timer.
- `abort_btn`  in  1  debounced abort button, level (present only with `GAME_CTRL_ABORT_EN`).
- `state_out`  out  2  MENU=00, READY=01, GAME=10, SCORE=11; reset 00.
- `time_out`  out  8  round length in seconds to the timer; reset 30.
- `countdown`  out  4  READY seconds remaining; reset 0.
- `game_start`  out  1  one-cycle pulse on entry to GAME; reset 0.
- `round_cnt`  out  8  completed rounds, saturates at 255; reset 0.

## Operation
- Start edge: `start_q` register; `start_rise = start_btn & ~start_q`. A button held through reset gives no edge.
- MENU: on `start_rise`, latch `time_out` from the `time_sel` lookup, load `countdown = READY_S`, clear the prescaler, and go to READY.
- READY: each tick decrements `countdown`. At the tick where `countdown == 1`, `countdown` becomes 0, the state goes to GAME, and `game_start` pulses.
- GAME: `time_out` is frozen. On `end_of_time`, go to SCORE, increment `round_cnt` (saturating), clear the prescaler, and load the SCORE hold counter with `SCORE_S`.
- SCORE: on `start_rise` or hold expiry (tick with hold == 1), go to MENU. If both happen in the same cycle, the result is the same: MENU.
- `start_rise` has no effect in READY or GAME. `end_of_time` has no effect outside GAME.
- `time_sel` changes outside the MENU→READY edge are ignored.

## Timing
- All outputs are registered. A state change appears one cycle after the qualifying input cycle.
- Tick: the prescaler counts 0..CLK_HZ-1 and asserts `tick` for one cycle at CLK_HZ-1. It is cleared on every state entry, so READY lasts exactly READY_S×CLK_HZ cycles.
- `game_start` is high in the first GAME cycle only.
- Asynchronous reset mid-operation returns all registers to their reset values immediately. The first state after reset release is MENU.

## Configuration
- `GAME_CTRL_ABORT_EN` defined:
  - `abort_btn` rising edge in READY or GAME → MENU next cycle.
  - `round_cnt` is unchanged and `game_start` is suppressed if the abort coincides with READY→GAME.
  - Abort has priority over `end_of_time` in the same cycle.
- Not defined: the port is absent and the abort logic is not built.

## Structure
- Shared package/header `game_pkg`:
  - state encodings MENU/READY/GAME/SCORE (GAME=2'b10, shared with the game timer);
  - the round length table 30/60/90/120.
- One sub-module, `sec_tick_gen`: prescaler with parameter CLK_HZ, `clr` input, one-cycle `tick` output.

## Test plan
All scenarios use CLK_HZ=10, READY_S=3, SCORE_S=2.
- Reset release with `start_btn`=1 held → stays MENU, all outputs at reset values. Release then press → READY next cycle, `countdown`=3.
- `time_sel`=2 at start, then change it to 0 during READY → `time_out`=90 throughout. GAME entered exactly 30 cycles after READY entry; `game_start` pulses one cycle.
- `end_of_time` pulse in GAME → SCORE next cycle, `round_cnt` 0→1. No further input → MENU 20 cycles later.
- `end_of_time` pulse in MENU or READY → no state change. Start press in GAME → no change.
- Run 256 rounds → `round_cnt` holds 255.
- With `GAME_CTRL_ABORT_EN`: abort and `end_of_time` in the same GAME cycle → MENU, `round_cnt` unchanged. Reset asserted mid-READY → MENU immediately.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: state encodings (shared with the game timer) and the round length table.
package game_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned TIME_W  = 8;
    localparam int unsigned CD_W    = 4;
    localparam int unsigned ROUND_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_MENU  = 2'b00,
        ST_READY = 2'b01,
        ST_GAME  = 2'b10,
        ST_SCORE = 2'b11
    } game_state_e;

    // Round length in seconds for each time_sel code.
    function automatic logic [TIME_W-1:0] round_len(input logic [1:0] sel);
        logic [TIME_W-1:0] len;
        case (sel)
            2'd0:    len = 8'd30;
            2'd1:    len = 8'd60;
            2'd2:    len = 8'd90;
            default: len = 8'd120;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/game_state_ctrl_sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1, tick is high on the last count; clr restarts the second.
module sec_tick_gen #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer MENU -> READY -> GAME -> SCORE -> MENU with internal second tick.
// Optional abort button enabled by defining GAME_CTRL_ABORT_EN.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned READY_S = 3,
    parameter int unsigned SCORE_S = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic [1:0]         time_sel,
    input  logic               end_of_time,
`ifdef GAME_CTRL_ABORT_EN
    input  logic               abort_btn,
`endif
    output logic [STATE_W-1:0] state_out,
    output logic [TIME_W-1:0]  time_out,
    output logic [CD_W-1:0]    countdown,
    output logic               game_start,
    output logic [ROUND_W-1:0] round_cnt
);

    game_state_e  r_state;
    logic         r_start_q;
    logic [7:0]   r_hold;

    logic w_start_rise;
    logic w_tick;
    logic w_abort;
    logic w_go_ready;
    logic w_go_game;
    logic w_go_score;
    logic w_go_menu;
    logic w_clr;

    assign state_out    = r_state;
    assign w_start_rise = start_btn & ~r_start_q;

`ifdef GAME_CTRL_ABORT_EN
    logic r_abort_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_abort_q <= 1'b1;
        end else begin
            r_abort_q <= abort_btn;
        end
    end

    assign w_abort = abort_btn & ~r_abort_q & ((r_state == ST_READY) || (r_state == ST_GAME));
`else
    assign w_abort = 1'b0;
`endif

    assign w_go_ready = (r_state == ST_MENU)  && w_start_rise;
    assign w_go_game  = (r_state == ST_READY) && w_tick && (countdown == 4'd1);
    assign w_go_score = (r_state == ST_GAME)  && end_of_time;
    assign w_go_menu  = (r_state == ST_SCORE) && (w_start_rise || (w_tick && (r_hold == 8'd1)));
    // Restart the second on every state entry so each phase lasts whole seconds.
    assign w_clr      = w_go_ready | w_go_game | w_go_score | w_go_menu | w_abort;

    sec_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_sec_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // Start edge register resets high so a button held through reset gives no edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start_q <= 1'b1;
        end else begin
            r_start_q <= start_btn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_MENU;
            time_out   <= 8'd30;
            countdown  <= '0;
            game_start <= 1'b0;
            round_cnt  <= '0;
            r_hold     <= '0;
        end else begin
            game_start <= 1'b0;
            if (w_abort) begin
                r_state   <= ST_MENU;
                countdown <= '0;
            end else begin
                case (r_state)
                    ST_MENU: begin
                        if (w_go_ready) begin
                            r_state   <= ST_READY;
                            time_out  <= round_len(time_sel);
                            countdown <= CD_W'(READY_S);
                        end
                    end
                    ST_READY: begin
                        if (w_tick) begin
                            countdown <= countdown - CD_W'(1);
                        end
                        if (w_go_game) begin
                            r_state    <= ST_GAME;
                            game_start <= 1'b1;
                        end
                    end
                    ST_GAME: begin
                        if (w_go_score) begin
                            r_state <= ST_SCORE;
                            r_hold  <= 8'(SCORE_S);
                            if (round_cnt != 8'hFF) begin
                                round_cnt <= round_cnt + ROUND_W'(1);
                            end
                        end
                    end
                    default: begin
                        if (w_go_menu) begin
                            r_state <= ST_MENU;
                        end else if (w_tick) begin
                            r_hold <= r_hold - 8'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
